decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter XLEN, default 64, meaning: data width of the immediate output; legal values 32 and 64.
REQ-002 Parameter CNT_W, default 32, meaning: width of the decoded-instruction counter.
REQ-003 clk  input  1  meaning: single clock; all state changes on its rising edge.
REQ-004 rst  input  1  meaning: reset, synchronous, active-high.
REQ-005 flush  input  1  meaning: discards all buffered instructions.
REQ-006 in_valid  input  1  meaning: in_instr and in_pc are valid.
REQ-007 in_ready  output  1  meaning: stage can accept an instruction this cycle.
REQ-008 in_instr  input  32  meaning: raw RV instruction word.
REQ-009 in_pc  input  XLEN  meaning: instruction address.
REQ-010 out_valid  output  1  meaning: decoded fields are valid.
REQ-011 out_ready  input  1  meaning: consumer accepts the output this cycle.
REQ-012 out_pc  output  XLEN  meaning: pc of the output instruction.
REQ-013 out_rs1, out_rs2, out_rd  output  5 each  meaning: instr[19:15], instr[24:20], instr[11:7].
REQ-014 out_opcode  output  7, out_funct3  output  3, out_funct7  output  7  meaning: instr[6:0], instr[14:12], instr[31:25].
REQ-015 out_imm  output  XLEN  meaning: sign-extended immediate for the decoded format.
REQ-016 out_fmt  output  3  meaning: R=0, I=1, S=2, B=3, U=4, J=5, illegal=7.
REQ-017 out_illegal  output  1  meaning: instruction not recognised.
REQ-018 dec_count  output  CNT_W  meaning: number of output handshakes since reset.

Function
REQ-019 Input handshake completes when in_valid and in_ready are both high on a rising edge; output handshake completes when out_valid and out_ready are both high on a rising edge.
REQ-020 Decode SHALL be registered: an instruction accepted in cycle N appears on the outputs in cycle N+1 at the earliest.
REQ-021 Storage SHALL be two entries: an output register plus a skid register; in_ready = skid register empty, independent of out_ready in the same cycle.
REQ-022 Outputs SHALL hold stable while out_valid=1 and out_ready=0.
REQ-023 On an output handshake with the skid register full, the skid contents move to the output register; if an input handshake occurs in the same cycle, the new instruction goes to the skid register.
REQ-024 Order SHALL be preserved; no instruction is dropped or duplicated.
REQ-025 Format by opcode: 0000011, 0010011, 1100111, 1110011 -> I; 0011011 -> I only when XLEN=64; 0110011 -> R; 0111011 -> R only when XLEN=64; 0100011 -> S; 1100011 -> B; 0110111, 0010111 -> U; 1101111 -> J.
REQ-026 Any other opcode, including instr[1:0] != 2'b11, SHALL give out_fmt=7, out_illegal=1, out_imm=0; the register and function fields still pass through.
REQ-027 Immediates, sign bit instr[31] replicated to XLEN: I = instr[31:20]; S = {instr[31:25], instr[11:7]}; B = {instr[31], instr[7], instr[30:25], instr[11:8], 0}; U = {instr[31:12], 12'b0}; J = {instr[31], instr[19:12], instr[20], instr[30:21], 0}; R = 0.
REQ-028 dec_count SHALL increment by 1 on each output handshake and wrap from all-ones to 0.
REQ-029 flush SHALL clear both entries at the next edge (out_valid=0, in_ready=1) and ignore any input handshake in that cycle; dec_count is unaffected except that an output handshake in the same cycle still counts.
REQ-030 rst takes priority over flush and all handshakes.

Reset
REQ-031 At the edge with rst=1: out_valid=0, skid empty, in_ready=1, dec_count=0, all data outputs=0, out_fmt=0, out_illegal=0.
REQ-032 While rst=1, in_ready SHALL stay 1 but no instruction is accepted; rst asserted mid-stream SHALL discard both buffered entries.

Verification
REQ-033 in_instr=0xFFF00293 (addi x5,x0,-1), out_ready=1 -> next cycle: out_fmt=1, rd=5, rs1=0, imm=0xFFFFFFFFFFFFFFFF, dec_count 0 -> 1 after the handshake.
REQ-034 in_instr=0x0021B423 (sd x2,8(x3)) -> out_fmt=2, rs1=3, rs2=2, funct3=3, imm=0x8; in_instr=0x12345537 (lui x10) -> out_fmt=4, rd=10, imm=0x0000000012345000.
REQ-035 in_instr=0x800000EF (jal x1) -> out_fmt=5, rd=1, imm=0xFFFFFFFFFFF00000; with XLEN=32 -> imm=0xFFF00000, and 0x0000001B (OP-IMM-32) -> out_illegal=1, out_fmt=7, imm=0.
REQ-036 Hold out_ready=0 and offer instructions A, B, C back-to-back -> A and B accepted, in_ready=0 while C is offered; raise out_ready -> outputs A, B, C in order, dec_count=3.
REQ-037 Skid register full, then assert flush for one cycle -> next cycle out_valid=0, in_ready=1, dec_count unchanged; then assert rst with one entry buffered -> all REQ-031 values.

Source files
------------

// File: rtl/decode_stage.sv
// decode_stage: two-entry registered RV instruction decoder with skid buffer.
module decode_stage #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rd,
  output logic [6:0]       out_opcode,
  output logic [2:0]       out_funct3,
  output logic [6:0]       out_funct7,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [CNT_W-1:0] dec_count
);
  localparam bit RV64 = (XLEN == 64);
  typedef struct packed {
    logic [2:0]      fmt;
    logic            illegal;
    logic [XLEN-1:0] imm;
  } dec_t;
  function automatic dec_t decode(input logic [31:0] i);
    dec_t d;
    logic [6:0] op;
    logic [31:0] imm32;
    op = i[6:0];
    d.fmt = (op == 7'b0000011 || op == 7'b0010011 || op == 7'b1100111 || op == 7'b1110011 ||
             (RV64 && op == 7'b0011011)) ? 3'd1 :
            (op == 7'b0110011 || (RV64 && op == 7'b0111011)) ? 3'd0 :
            (op == 7'b0100011) ? 3'd2 :
            (op == 7'b1100011) ? 3'd3 :
            (op == 7'b0110111 || op == 7'b0010111) ? 3'd4 :
            (op == 7'b1101111) ? 3'd5 : 3'd7;
    d.illegal = (d.fmt == 3'd7);
    imm32 = (d.fmt == 3'd1) ? {{20{i[31]}}, i[31:20]} :
            (d.fmt == 3'd2) ? {{20{i[31]}}, i[31:25], i[11:7]} :
            (d.fmt == 3'd3) ? {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0} :
            (d.fmt == 3'd4) ? {i[31:12], 12'b0} :
            (d.fmt == 3'd5) ? {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0} : 32'd0;
    d.imm = XLEN'($signed(imm32));
    return d;
  endfunction
  logic            out_v, skid_v, in_fire, out_fire, load;
  logic [31:0]     out_i, skid_i, nxt_i;
  logic [XLEN-1:0] out_pc_r, skid_pc, nxt_pc;
  dec_t            out_d;
  logic [CNT_W-1:0] cnt;
  // The skid entry is only ever full while the output entry is full, so
  // the output register reloads from skid when draining, else from the input.
  always_comb begin
    in_fire  = in_valid & ~skid_v & ~rst;
    out_fire = out_v & out_ready;
    load     = out_fire ? (skid_v | in_fire) : (~out_v & in_fire);
    nxt_i    = skid_v ? skid_i : in_instr;
    nxt_pc   = skid_v ? skid_pc : in_pc;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_v    <= 1'b0;
      skid_v   <= 1'b0;
      out_i    <= '0;
      out_pc_r <= '0;
      out_d    <= '0;
      skid_i   <= '0;
      skid_pc  <= '0;
      cnt      <= '0;
    end else begin
      cnt <= cnt + CNT_W'(out_fire);
      if (flush) begin
        out_v  <= 1'b0;
        skid_v <= 1'b0;
      end else begin
        if (load) begin
          out_i    <= nxt_i;
          out_pc_r <= nxt_pc;
          out_d    <= decode(nxt_i);
        end
        if (in_fire & ~load) begin
          skid_i  <= in_instr;
          skid_pc <= in_pc;
        end
        out_v  <= load | (out_v & ~out_fire);
        skid_v <= (skid_v & ~out_fire) | (in_fire & ~load);
      end
    end
  end
  assign in_ready    = rst | ~skid_v;
  assign out_valid   = out_v;
  assign out_pc      = out_pc_r;
  assign out_rs1     = out_i[19:15];
  assign out_rs2     = out_i[24:20];
  assign out_rd      = out_i[11:7];
  assign out_opcode  = out_i[6:0];
  assign out_funct3  = out_i[14:12];
  assign out_funct7  = out_i[31:25];
  assign out_imm     = out_d.imm;
  assign out_fmt     = out_d.fmt;
  assign out_illegal = out_d.illegal;
  assign dec_count   = cnt;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: table vectors, directed handshake sequences and random traffic vs a queue model.
module tb_decode_stage;
  logic clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic [31:0] in_instr = 0;
  logic [63:0] in_pc = 0;
  logic a_in_ready, a_out_valid, a_ill;
  logic [63:0] a_pc, a_imm;
  logic [4:0] a_rs1, a_rs2, a_rd;
  logic [6:0] a_op, a_f7;
  logic [2:0] a_f3, a_fmt;
  logic [31:0] a_cnt;
  logic b_in_ready, b_out_valid, b_ill;
  logic [31:0] b_pc, b_imm;
  logic [4:0] b_rs1, b_rs2, b_rd;
  logic [6:0] b_op, b_f7;
  logic [2:0] b_f3, b_fmt;
  logic [3:0] b_cnt;
  int checks = 0, failures = 0;
  typedef struct { logic [31:0] ins; logic [63:0] pc; } ent_t;
  ent_t q[$];
  int unsigned cnt = 0;
  typedef struct {
    logic [31:0] ins; logic [2:0] fmt; logic [4:0] rd, rs1, rs2;
    logic [63:0] imm; logic [2:0] fmt32; logic [31:0] imm32;
  } vec_t;
  vec_t tbl[8];
  logic [6:0] ops[14] = '{7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011, 7'b0011011, 7'b0110011,
                          7'b0111011, 7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111,
                          7'b0001111, 7'b1111111};

  decode_stage #(.XLEN(64), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_pc(a_pc), .out_rs1(a_rs1), .out_rs2(a_rs2), .out_rd(a_rd), .out_opcode(a_op),
    .out_funct3(a_f3), .out_funct7(a_f7), .out_imm(a_imm), .out_fmt(a_fmt),
    .out_illegal(a_ill), .dec_count(a_cnt));
  decode_stage #(.XLEN(32), .CNT_W(4)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_instr(in_instr), .in_pc(in_pc[31:0]), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_pc(b_pc), .out_rs1(b_rs1), .out_rs2(b_rs2), .out_rd(b_rd), .out_opcode(b_op),
    .out_funct3(b_f3), .out_funct7(b_f7), .out_imm(b_imm), .out_fmt(b_fmt),
    .out_illegal(b_ill), .dec_count(b_cnt));

  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  // Immediates assembled arithmetically from a sign-extended word.
  function automatic void ref_dec(input logic [31:0] i, input bit rv64,
                                  output logic [2:0] fmt, output logic [63:0] imm);
    longint sx, hi;
    sx = longint'($signed(i));
    case (i[6:0])
      7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011: fmt = 1;
      7'b0011011: fmt = rv64 ? 3'd1 : 3'd7;
      7'b0110011: fmt = 0;
      7'b0111011: fmt = rv64 ? 3'd0 : 3'd7;
      7'b0100011: fmt = 2;
      7'b1100011: fmt = 3;
      7'b0110111, 7'b0010111: fmt = 4;
      7'b1101111: fmt = 5;
      default: fmt = 7;
    endcase
    case (fmt)
      3'd1: begin hi = sx >>> 20; imm = hi; end
      3'd2: begin hi = sx >>> 25; imm = (hi << 5) | 64'(i[11:7]); end
      3'd3: begin hi = sx >>> 31; imm = (hi << 12) | (64'(i[7]) << 11) | (64'(i[30:25]) << 5) | (64'(i[11:8]) << 1); end
      3'd4: imm = sx & ~64'hFFF;
      3'd5: begin hi = sx >>> 31; imm = (hi << 20) | (64'(i[19:12]) << 12) | (64'(i[20]) << 11) | (64'(i[30:21]) << 1); end
      default: imm = 0;
    endcase
  endfunction

  task automatic check_state();
    logic [2:0] f;
    logic [63:0] im;
    logic [31:0] x;
    chk("a_in_ready", a_in_ready, rst || q.size() < 2);
    chk("b_in_ready", b_in_ready, rst || q.size() < 2);
    chk("a_out_valid", a_out_valid, q.size() > 0);
    chk("b_out_valid", b_out_valid, q.size() > 0);
    chk("a_count", a_cnt, 64'(cnt));
    chk("b_count", b_cnt, 64'(cnt & 15));
    if (q.size() > 0) begin
      x = q[0].ins;
      ref_dec(x, 1, f, im);
      chk("a_fmt", a_fmt, f);
      chk("a_illegal", a_ill, f == 7);
      chk("a_imm", a_imm, im);
      chk("a_pc", a_pc, q[0].pc);
      chk("a_fields", {a_f7, a_rs2, a_rs1, a_f3, a_rd, a_op}, x);
      ref_dec(x, 0, f, im);
      chk("b_fmt", b_fmt, f);
      chk("b_illegal", b_ill, f == 7);
      chk("b_imm", b_imm, im[31:0]);
      chk("b_pc", b_pc, q[0].pc[31:0]);
      chk("b_fields", {b_f7, b_rs2, b_rs1, b_f3, b_rd, b_op}, x);
    end
  endtask

  task automatic cycle(input bit r, input bit f, input bit iv, input logic [31:0] ins,
                       input logic [63:0] pc, input bit ordy);
    bit of, inf;
    rst = r; flush = f; in_valid = iv; in_instr = ins; in_pc = pc; out_ready = ordy;
    if (r) begin
      q = {};
      cnt = 0;
    end else begin
      of  = q.size() > 0 && ordy;
      inf = iv && q.size() < 2;
      if (of) cnt++;
      if (f) q = {};
      else begin
        if (of) void'(q.pop_front());
        if (inf) q.push_back('{ins, pc});
      end
    end
    @(posedge clk);
    #1;
    check_state();
  endtask

  task automatic check_reset();
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_in_ready", a_in_ready, 1);
    chk("rst_count", a_cnt, 0);
    chk("rst_pc", a_pc, 0);
    chk("rst_imm", a_imm, 0);
    chk("rst_fmt", a_fmt, 0);
    chk("rst_illegal", a_ill, 0);
    chk("rst_fields", {a_f7, a_rs2, a_rs1, a_f3, a_rd, a_op}, 0);
    chk("rst32_fmt_ill_imm", {b_fmt, b_ill, b_imm, b_pc}, 0);
  endtask

  initial begin
    logic [31:0] r;
    tbl[0] = '{32'hFFF00293, 3'd1, 5'd5, 5'd0, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 32'hFFFF_FFFF};
    tbl[1] = '{32'h0021B423, 3'd2, 5'd8, 5'd3, 5'd2, 64'h8, 3'd2, 32'h8};
    tbl[2] = '{32'h12345537, 3'd4, 5'd10, 5'd8, 5'd3, 64'h1234_5000, 3'd4, 32'h1234_5000};
    tbl[3] = '{32'h800000EF, 3'd5, 5'd1, 5'd0, 5'd0, 64'hFFFF_FFFF_FFF0_0000, 3'd5, 32'hFFF0_0000};
    tbl[4] = '{32'h0000001B, 3'd1, 5'd0, 5'd0, 5'd0, 64'h0, 3'd7, 32'h0};
    tbl[5] = '{32'h00000001, 3'd7, 5'd0, 5'd0, 5'd0, 64'h0, 3'd7, 32'h0};
    tbl[6] = '{32'h003100B3, 3'd0, 5'd1, 5'd2, 5'd3, 64'h0, 3'd0, 32'h0};
    tbl[7] = '{32'hFE000FE3, 3'd3, 5'd31, 5'd0, 5'd0, 64'hFFFF_FFFF_FFFF_FFFE, 3'd3, 32'hFFFF_FFFE};
    // Reset held with input offered: nothing is accepted.
    cycle(1, 0, 1, 32'hFFF00293, 64'h40, 1);
    cycle(1, 0, 1, 32'hFFF00293, 64'h40, 1);
    check_reset();
    // Table vectors, streamed back to back with the consumer always ready.
    foreach (tbl[k]) begin
      cycle(0, 0, 1, tbl[k].ins, 64'h1000 + 64'(k * 4), 1);
      if (k == 0) chk("count_first", a_cnt, 0);
      chk("tv_valid", a_out_valid, 1);
      chk("tv_fmt", a_fmt, tbl[k].fmt);
      chk("tv_illegal", a_ill, tbl[k].fmt == 7);
      chk("tv_imm", a_imm, tbl[k].imm);
      chk("tv_regs", {a_rd, a_rs1, a_rs2}, {tbl[k].rd, tbl[k].rs1, tbl[k].rs2});
      chk("tv32_fmt", b_fmt, tbl[k].fmt32);
      chk("tv32_illegal", b_ill, tbl[k].fmt32 == 7);
      chk("tv32_imm", b_imm, tbl[k].imm32);
    end
    cycle(0, 0, 0, 0, 0, 1);
    chk("tv_count", a_cnt, 8);
    chk("tv_count32_wrap", b_cnt, 8);
    // Back-pressure: A, B fill both entries, C is refused until drained.
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 0, 1, 32'h00100093, 64'h100, 0);
    cycle(0, 0, 1, 32'h00200113, 64'h104, 0);
    cycle(0, 0, 1, 32'h00300193, 64'h108, 0);
    chk("full_in_ready", a_in_ready, 0);
    chk("hold_pc", a_pc, 64'h100);
    cycle(0, 0, 1, 32'h00300193, 64'h108, 0);
    chk("hold_pc2", a_pc, 64'h100);
    cycle(0, 0, 1, 32'h00300193, 64'h108, 1);
    chk("order_b", a_pc, 64'h104);
    cycle(0, 0, 1, 32'h00300193, 64'h108, 1);
    chk("order_c", a_pc, 64'h108);
    cycle(0, 0, 0, 0, 0, 1);
    chk("abc_count", a_cnt, 3);
    // Flush with skid full, then reset with one entry buffered.
    cycle(0, 0, 1, 32'h00400213, 64'h200, 0);
    cycle(0, 0, 1, 32'h00500293, 64'h204, 0);
    cycle(0, 1, 1, 32'h00600313, 64'h208, 0);
    chk("flush_valid", a_out_valid, 0);
    chk("flush_ready", a_in_ready, 1);
    chk("flush_count", a_cnt, 3);
    cycle(0, 0, 1, 32'h00700393, 64'h20C, 0);
    cycle(0, 1, 0, 0, 0, 1);
    chk("flush_fire_count", a_cnt, 4);
    cycle(0, 0, 1, 32'h00700393, 64'h210, 0);
    cycle(1, 0, 1, 32'h00800413, 64'h214, 1);
    check_reset();
    // Random traffic against the queue model.
    for (int n = 0; n < 1500; n++) begin
      r = $urandom();
      if ($urandom_range(7) != 0) r[6:0] = ops[$urandom_range(13)];
      cycle($urandom_range(99) == 0, $urandom_range(31) == 0, $urandom_range(3) != 0, r,
            {$urandom(), $urandom()}, $urandom_range(2) != 0);
    end
    cycle(1, 0, 0, 0, 0, 0);
    check_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
